store_write_buffer: RTL and testbench

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

---
 rtl/store_write_buffer_if.sv | 27 ++
 rtl/store_write_buffer.sv | 70 +++++++
 tb/tb_store_write_buffer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/store_write_buffer_if.sv
// store_write_buffer_if: pipeline store port and memory write port of the store write buffer.
interface store_write_buffer_if #(
    parameter int DEPTH = 4
);
    logic                     st_valid;
    logic                     st_ready;
    logic [1:0]               st_type;
    logic [31:0]              st_addr;
    logic [31:0]              st_data;
    logic                     st_exc;
    logic                     mem_req;
    logic                     mem_ack;
    logic [31:0]              mem_addr;
    logic [31:0]              mem_wdata;
    logic [3:0]               mem_byteen;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output st_valid, st_type, st_addr, st_data, mem_ack,
        input  st_ready, st_exc, mem_req, mem_addr, mem_wdata, mem_byteen, count
    );

    modport slave (
        input  st_valid, st_type, st_addr, st_data, mem_ack,
        output st_ready, st_exc, mem_req, mem_addr, mem_wdata, mem_byteen, count
    );
endinterface

// File: rtl/store_write_buffer.sv
// store_write_buffer: in-order store FIFO that turns sb/sh/sw requests into
// word-aligned memory writes with byte enables and flags misaligned stores.
module store_write_buffer #(
    parameter int DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    store_write_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          exc_q, exc_d;
    logic          hs, mis, enq, deq;
    logic [3:0]    be_new;
    logic [31:0]   data_new;

    assign bus.st_ready   = cnt_q < (AW+1)'(DEPTH);
    assign bus.mem_req    = cnt_q != '0;
    assign bus.mem_addr   = addr_q[rd_q];
    assign bus.mem_wdata  = data_q[rd_q];
    assign bus.mem_byteen = be_q[rd_q];
    assign bus.count      = cnt_q;
    assign bus.st_exc     = exc_q;

    always_comb begin
        hs       = bus.st_valid && bus.st_ready;
        mis      = bus.st_type == 2'b10 ? bus.st_addr[0] :
                   bus.st_type == 2'b11 ? |bus.st_addr[1:0] : 1'b0;
        enq      = hs && bus.st_type != 2'b00 && !mis;
        deq      = bus.mem_req && bus.mem_ack;
        be_new   = bus.st_type == 2'b01 ? 4'b0001 << bus.st_addr[1:0] :
                   bus.st_type == 2'b10 ? (bus.st_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        data_new = bus.st_type == 2'b01 ? {4{bus.st_data[7:0]}} :
                   bus.st_type == 2'b10 ? {2{bus.st_data[15:0]}} : bus.st_data;
        wr_d     = enq ? wr_q + 1'b1 : wr_q;
        rd_d     = deq ? rd_q + 1'b1 : rd_q;
        cnt_d    = cnt_q + (AW+1)'(enq) - (AW+1)'(deq);
        exc_d    = hs && mis;
    end

    // Entries are cleared on reset so the idle memory port reads back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            exc_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            exc_q <= exc_d;
            if (enq) begin
                addr_q[wr_q] <= {bus.st_addr[31:2], 2'b00};
                data_q[wr_q] <= data_new;
                be_q[wr_q]   <= be_new;
            end
        end
    end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed table-driven check of the store write buffer
// plus hand-written reset sequences.
module tb_store_write_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    store_write_buffer_if #(.DEPTH(4)) bus ();

    store_write_buffer #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic        vl;
        logic [1:0]  ty;
        logic [31:0] a;
        logic [31:0] d;
        logic        ak;
        logic [2:0]  c;
        logic        rq;
        logic        rd;
        logic        ex;
        logic        ck;
        logic [31:0] ma;
        logic [31:0] mw;
        logic [3:0]  be;
    } vec_t;

    vec_t tv [31];

    function automatic vec_t mk(input int vl, input int ty, input logic [31:0] a, input logic [31:0] d,
                                input int ak, input int c, input int rq, input int rd, input int ex,
                                input int ck, input logic [31:0] ma, input logic [31:0] mw, input int be);
        vec_t r;
        r.vl = 1'(vl); r.ty = 2'(ty); r.a = a; r.d = d; r.ak = 1'(ak);
        r.c = 3'(c); r.rq = 1'(rq); r.rd = 1'(rd); r.ex = 1'(ex);
        r.ck = 1'(ck); r.ma = ma; r.mw = mw; r.be = 4'(be);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input vec_t v);
        chk({tag, " count"}, 32'(bus.count), 32'(v.c));
        chk({tag, " mem_req"}, 32'(bus.mem_req), 32'(v.rq));
        chk({tag, " st_ready"}, 32'(bus.st_ready), 32'(v.rd));
        chk({tag, " st_exc"}, 32'(bus.st_exc), 32'(v.ex));
        if (v.ck) begin
            chk({tag, " mem_addr"}, bus.mem_addr, v.ma);
            chk({tag, " mem_wdata"}, bus.mem_wdata, v.mw);
            chk({tag, " mem_byteen"}, 32'(bus.mem_byteen), 32'(v.be));
        end
    endtask

    task automatic step(input string tag, input vec_t v);
        bus.st_valid = v.vl;
        bus.st_type  = v.ty;
        bus.st_addr  = v.a;
        bus.st_data  = v.d;
        bus.mem_ack  = v.ak;
        @(posedge clk);
        #1;
        check_state(tag, v);
    endtask

    initial begin
        bus.st_valid = 1'b0;
        bus.st_type  = 2'b00;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.mem_ack  = 1'b0;

        tv[0]  = mk(0, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 0);
        tv[1]  = mk(1, 1, 'h1003, 'hAB, 1,     1, 1, 1, 0, 1, 'h1000, 'hABABABAB, 'b1000);
        tv[2]  = mk(0, 0, 0, 0, 1,            0, 0, 1, 0, 0, 0, 0, 0);
        tv[3]  = mk(1, 2, 'h2002, 'h1234, 0,   1, 1, 1, 0, 1, 'h2000, 'h12341234, 'b1100);
        tv[4]  = mk(1, 3, 'h2004, 'hDEADBEEF, 0, 2, 1, 1, 0, 1, 'h2000, 'h12341234, 'b1100);
        tv[5]  = mk(0, 0, 0, 0, 1,            1, 1, 1, 0, 1, 'h2004, 'hDEADBEEF, 'b1111);
        tv[6]  = mk(0, 0, 0, 0, 1,            0, 0, 1, 0, 0, 0, 0, 0);
        tv[7]  = mk(1, 3, 'h3001, 'h55, 0,     0, 0, 1, 1, 0, 0, 0, 0);
        tv[8]  = mk(0, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 0);
        tv[9]  = mk(1, 2, 'h3003, 'h66, 0,     0, 0, 1, 1, 0, 0, 0, 0);
        tv[10] = mk(1, 1, 'h3001, 'h5A, 0,     1, 1, 1, 0, 1, 'h3000, 'h5A5A5A5A, 'b0010);
        tv[11] = mk(1, 0, 'h9999, 'h1, 0,      1, 1, 1, 0, 1, 'h3000, 'h5A5A5A5A, 'b0010);
        tv[12] = mk(1, 2, 'h4000, 'hFFFF8765, 1, 1, 1, 1, 0, 1, 'h4000, 'h87658765, 'b0011);
        tv[13] = mk(1, 1, 'h4002, 'h11, 1,     1, 1, 1, 0, 1, 'h4000, 'h11111111, 'b0100);
        tv[14] = mk(1, 3, 'h5000, 'hCAFEF00D, 0, 2, 1, 1, 0, 1, 'h4000, 'h11111111, 'b0100);
        tv[15] = mk(1, 3, 'h5004, 'h01020304, 1, 2, 1, 1, 0, 1, 'h5000, 'hCAFEF00D, 'b1111);
        tv[16] = mk(1, 3, 'h5008, 'h0A0B0C0D, 1, 2, 1, 1, 0, 1, 'h5004, 'h01020304, 'b1111);
        tv[17] = mk(0, 0, 0, 0, 1,            1, 1, 1, 0, 1, 'h5008, 'h0A0B0C0D, 'b1111);
        tv[18] = mk(0, 0, 0, 0, 1,            0, 0, 1, 0, 0, 0, 0, 0);
        tv[19] = mk(1, 3, 'h3002, 'h77, 0,     0, 0, 1, 1, 0, 0, 0, 0);
        tv[20] = mk(1, 3, 'h6000, 'h6000, 0,   1, 1, 1, 0, 1, 'h6000, 'h6000, 'b1111);
        tv[21] = mk(1, 3, 'h6004, 'h6004, 0,   2, 1, 1, 0, 1, 'h6000, 'h6000, 'b1111);
        tv[22] = mk(1, 3, 'h6008, 'h6008, 0,   3, 1, 1, 0, 1, 'h6000, 'h6000, 'b1111);
        tv[23] = mk(1, 3, 'h600C, 'h600C, 0,   4, 1, 0, 0, 1, 'h6000, 'h6000, 'b1111);
        tv[24] = mk(1, 3, 'h6010, 'h6010, 0,   4, 1, 0, 0, 1, 'h6000, 'h6000, 'b1111);
        tv[25] = mk(1, 3, 'h6010, 'h6010, 1,   3, 1, 1, 0, 1, 'h6004, 'h6004, 'b1111);
        tv[26] = mk(1, 3, 'h6010, 'h6010, 0,   4, 1, 0, 0, 1, 'h6004, 'h6004, 'b1111);
        tv[27] = mk(0, 0, 0, 0, 1,            3, 1, 1, 0, 1, 'h6008, 'h6008, 'b1111);
        tv[28] = mk(0, 0, 0, 0, 1,            2, 1, 1, 0, 1, 'h600C, 'h600C, 'b1111);
        tv[29] = mk(0, 0, 0, 0, 1,            1, 1, 1, 0, 1, 'h6010, 'h6010, 'b1111);
        tv[30] = mk(0, 0, 0, 0, 1,            0, 0, 1, 0, 0, 0, 0, 0);

        #12;
        check_state("reset", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        rst_n = 1'b1;

        for (int i = 0; i < 31; i++) step($sformatf("vec%0d", i), tv[i]);

        step("fill0", mk(1, 3, 'h7000, 'h1, 0, 1, 1, 1, 0, 1, 'h7000, 'h1, 'b1111));
        step("fill1", mk(1, 3, 'h7004, 'h2, 0, 2, 1, 1, 0, 1, 'h7000, 'h1, 'b1111));
        step("fill2", mk(1, 3, 'h7008, 'h3, 0, 3, 1, 1, 0, 1, 'h7000, 'h1, 'b1111));
        bus.st_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async_rst", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        #3;
        rst_n = 1'b1;
        step("resume", mk(1, 1, 'h8001, 'h77, 0, 1, 1, 1, 0, 1, 'h8000, 'h77777777, 'b0010));
        step("resume_drain", mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
